wport_arbiter: RTL

//  Shares the register file's single write port between two sources:
//   - the pipeline WB stage, which cannot be back-pressured;
//   - the long-latency unit (LLU: divider/multi-cycle ops), which uses a valid/ready handshake.

---
 rtl/wport_arbiter_if.sv | 43 ++++
 rtl/wport_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/wport_arbiter_if.sv
// rtl/wport_arbiter_if.sv - write-port arbiter bus: WB, LLU, issue, ID read and regfile write signals
interface wport_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          pipe_we;
    logic [AW-1:0] pipe_waddr;
    logic [DW-1:0] pipe_wdata;
    logic          llu_valid;
    logic          llu_ready;
    logic [AW-1:0] llu_waddr;
    logic [DW-1:0] llu_wdata;
    logic          iss_valid;
    logic [AW-1:0] iss_waddr;
    logic          re1;
    logic          re2;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic          hazard;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pipe_drop;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output llu_valid, llu_waddr, llu_wdata,
        output iss_valid, iss_waddr,
        output re1, re2, raddr1, raddr2,
        input  llu_ready, hazard, stall_req,
        input  rf_we, rf_waddr, rf_wdata, pipe_drop
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  llu_valid, llu_waddr, llu_wdata,
        input  iss_valid, iss_waddr,
        input  re1, re2, raddr1, raddr2,
        output llu_ready, hazard, stall_req,
        output rf_we, rf_waddr, rf_wdata, pipe_drop
    );
endinterface

// File: rtl/wport_arbiter.sv
// rtl/wport_arbiter.sv - regfile write-port arbiter for WB and LLU with pending scoreboard and starvation guard
// Optional WPORT_PERF_EN adds the conflict_cnt performance counter.
module wport_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    wport_arbiter_if.slave    bus
`ifdef WPORT_PERF_EN
    ,
    output logic [31:0]       conflict_cnt
`endif
);
    localparam int NREG = 1 << AW;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);

    logic            hold_valid;
    logic [AW-1:0]   hold_waddr;
    logic [DW-1:0]   hold_wdata;
    logic [CW-1:0]   starve_cnt;
    logic            stall_r;
    logic            drop_r;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic pipe_slot;
    logic hold_grant;
    logic pipe_grant;
    logic llu_load;
    logic byp1;
    logic byp2;

    assign pipe_slot  = bus.pipe_we & (bus.pipe_waddr != '0);
    // The hold only beats WB when WB has nothing to write or the guard has forced a bubble.
    assign hold_grant = hold_valid & (stall_r | ~pipe_slot);
    assign pipe_grant = pipe_slot & ~hold_grant;
    assign llu_load   = bus.llu_valid & ~hold_valid;

    assign bus.llu_ready = ~hold_valid;
    assign bus.stall_req = stall_r;
    assign bus.pipe_drop = drop_r;

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = bus.pipe_waddr;
        bus.rf_wdata = bus.pipe_wdata;
        if (hold_grant) begin
            bus.rf_we    = ~rst & (hold_waddr != '0);
            bus.rf_waddr = hold_waddr;
            bus.rf_wdata = hold_wdata;
        end else if (pipe_grant) begin
            bus.rf_we    = ~rst;
        end
    end

    assign byp1       = hold_grant & (hold_waddr == bus.raddr1);
    assign byp2       = hold_grant & (hold_waddr == bus.raddr2);
    assign bus.hazard = ~rst & ((bus.re1 & pending[bus.raddr1] & ~byp1) |
                                (bus.re2 & pending[bus.raddr2] & ~byp2));

    // Issue set is applied after the drain clear so a same-address collision stays pending.
    always_comb begin
        pending_nxt = pending;
        if (hold_grant)
            pending_nxt[hold_waddr] = 1'b0;
        if (bus.iss_valid && bus.iss_waddr != '0)
            pending_nxt[bus.iss_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_waddr <= '0;
            hold_wdata <= '0;
            starve_cnt <= '0;
            stall_r    <= 1'b0;
            drop_r     <= 1'b0;
            pending    <= '0;
        end else begin
            pending <= pending_nxt;
            if (hold_grant) begin
                hold_valid <= 1'b0;
                starve_cnt <= '0;
                stall_r    <= 1'b0;
                if (stall_r && pipe_slot)
                    drop_r <= 1'b1;
            end else if (hold_valid) begin
                if (starve_cnt != CW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt >= CW'(STARVE_LIMIT - 1))
                    stall_r <= 1'b1;
            end
            if (llu_load) begin
                hold_valid <= 1'b1;
                hold_waddr <= bus.llu_waddr;
                hold_wdata <= bus.llu_wdata;
                starve_cnt <= '0;
            end
        end
    end

`ifdef WPORT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (hold_valid && pipe_slot)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif
endmodule
